// File: rtl/mac_ctrl.sv
// mac_ctrl: dot-product front end that sequences an external
// accumulator register through clear, LEN accumulates and result hand-off.
module mac_ctrl #(
  parameter int DW  = 8,
  parameter int RW  = 3 * DW,
  parameter int LEN = 4,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          sum_we,
  output logic          sum_zero,
  output logic [RW-1:0] sum_in,
  input  logic [RW-1:0] sum_q,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [RW-1:0] res_data,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    ACC,
    DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [2*DW-1:0] prod;
  logic [RW-1:0]   prod_rw;
  logic [RW:0]     add;
  logic            accept;
  logic            last;

  // product is zero-extended or truncated to the accumulator width
  assign prod    = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  assign prod_rw = RW'(prod);

  // one extra bit keeps the carry-out for the sticky overflow flag
  assign add    = {1'b0, sum_q} + {1'b0, prod_rw};
  assign sum_in = add[RW-1:0];

  // the accumulator is frozen in DONE, so sum_q is the stable result
  assign res_data = sum_q;

  // controls decode from state only; res_ready never reaches them
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACC);
  assign sum_zero  = (state == CLEAR);
  assign res_valid = (state == DONE);
  assign accept    = in_ready & in_valid;
  assign sum_we    = accept;
  assign last      = (count == CW'(LEN - 1));

  // sequencer: start only in IDLE, one clear cycle, LEN accepts, hand-off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          count <= '0;
          ovf   <= 1'b0;
          state <= ACC;
        end
        ACC: begin
          if (accept) begin
            count <= count + 1'b1;
            if (add[RW]) ovf <= 1'b1;
            if (last) state <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
